// File: rtl/alureg_seq.sv
// 8085-style byte-stream ALU/register sequencer: fetch opcode, optional operand, execute, write back.
// state  | meaning
// FETCH  | accept opcode byte
// OPER   | accept operand byte (M / immediate)
// EXEC   | retire: write regs/flags, strobe memory, flag illegal
// HALT   | stopped until rst
module alureg_seq #(
    parameter int DATASIZE = 8,
    parameter int FLAG_S   = 7,
    parameter int FLAG_Z   = 6,
    parameter int FLAG_A   = 4,
    parameter int FLAG_P   = 2,
    parameter int FLAG_C   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iVLD,
    input  logic [DATASIZE-1:0] iDAT,
    output logic                oRDY,
    output logic                oDONE,
    output logic                oILL,
    output logic                oHLT,
    output logic                oMWR,
    output logic [DATASIZE-1:0] oMDT,
    output logic [DATASIZE-1:0] oACC,
    output logic [DATASIZE-1:0] oFLG,
    input  logic [2:0]          iRSEL,
    output logic [DATASIZE-1:0] oRDAT
);

    typedef enum logic [1:0] {S_FETCH, S_OPER, S_EXEC, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [7:0]          op_q, op_d;
    logic [DATASIZE-1:0] opnd_q, opnd_d;
    logic [DATASIZE-1:0] f_q, f_d;
    logic [DATASIZE-1:0] rf_q [0:7];

    logic                rf_we;
    logic [2:0]          rf_idx;
    logic [DATASIZE-1:0] rf_val;
    logic [7:0]          idat_op;

    // Opcode lives in the low byte of the stream word; narrow datapaths zero-fill it.
    for (genvar gi = 0; gi < 8; gi++) begin : g_op
        if (gi < DATASIZE) begin : g_bit
            assign idat_op[gi] = iDAT[gi];
        end else begin : g_zero
            assign idat_op[gi] = 1'b0;
        end
    end

    function automatic logic needs_operand(input logic [7:0] b);
        logic r;
        r = 1'b0;
        case (b[7:6])
            2'b01:   r = (b[2:0] == 3'b110) && (b != 8'h76);
            2'b10,
            2'b11:   r = (b[2:0] == 3'b110);
            default: r = (b[2:0] == 3'b110) ||
                         (((b[2:0] == 3'b100) || (b[2:0] == 3'b101)) && (b[5:3] == 3'b110));
        endcase
        return r;
    endfunction

    function automatic logic [DATASIZE-1:0] mk_flags(input logic [DATASIZE-1:0] r,
                                                     input logic a, input logic c);
        logic [DATASIZE-1:0] f;
        f         = '0;
        f[FLAG_S] = r[DATASIZE-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_A] = a;
        f[FLAG_P] = ~^r;
        f[FLAG_C] = c;
        return f;
    endfunction

    logic [2:0]          ddd, sss, ooo;
    logic [DATASIZE-1:0] acc, src_val, dst_val;
    logic                cin;
    logic [DATASIZE:0]   add_w, sub_w;
    logic [4:0]          add_n, sub_n;
    logic [DATASIZE-1:0] alu_res, inc_res, dec_res;
    logic                alu_c, alu_a;

    assign ddd     = op_q[5:3];
    assign sss     = op_q[2:0];
    assign ooo     = op_q[5:3];
    assign acc     = rf_q[7];
    assign src_val = (sss == 3'b110) ? opnd_q : rf_q[sss];
    assign dst_val = (ddd == 3'b110) ? opnd_q : rf_q[ddd];
    // Carry-in only for ADC/SBB; CMP shares ooo[0]=1 but must ignore it.
    assign cin     = (ooo == 3'b001 || ooo == 3'b011) ? f_q[FLAG_C] : 1'b0;
    assign add_w   = {1'b0, acc} + {1'b0, src_val} + (DATASIZE+1)'(cin);
    assign sub_w   = {1'b0, acc} - {1'b0, src_val} - (DATASIZE+1)'(cin);
    assign add_n   = {1'b0, acc[3:0]} + {1'b0, src_val[3:0]} + 5'(cin);
    assign sub_n   = {1'b0, acc[3:0]} - {1'b0, src_val[3:0]} - 5'(cin);
    assign inc_res = dst_val + DATASIZE'(1);
    assign dec_res = dst_val - DATASIZE'(1);

    always_comb begin
        alu_res = sub_w[DATASIZE-1:0];
        alu_c   = sub_w[DATASIZE];
        alu_a   = sub_n[4];
        case (ooo)
            3'b000, 3'b001: begin
                alu_res = add_w[DATASIZE-1:0];
                alu_c   = add_w[DATASIZE];
                alu_a   = add_n[4];
            end
            3'b100: begin alu_res = acc & src_val; alu_c = 1'b0; alu_a = 1'b1; end
            3'b101: begin alu_res = acc ^ src_val; alu_c = 1'b0; alu_a = 1'b0; end
            3'b110: begin alu_res = acc | src_val; alu_c = 1'b0; alu_a = 1'b0; end
            default: ;
        endcase
    end

    always_comb begin
        logic                dst_wr;
        logic [DATASIZE-1:0] dst_res;
        logic                alu_go;
        state_d = state_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        f_d     = f_q;
        oRDY    = 1'b0;
        oDONE   = 1'b0;
        oILL    = 1'b0;
        oHLT    = 1'b0;
        oMWR    = 1'b0;
        oMDT    = '0;
        rf_we   = 1'b0;
        rf_idx  = 3'd0;
        rf_val  = '0;
        dst_wr  = 1'b0;
        dst_res = '0;
        alu_go  = 1'b0;
        case (state_q)
            S_FETCH: begin
                oRDY = 1'b1;
                if (iVLD) begin
                    op_d    = idat_op;
                    state_d = needs_operand(idat_op) ? S_OPER : S_EXEC;
                end
            end
            S_OPER: begin
                oRDY = 1'b1;
                if (iVLD) begin
                    opnd_d  = iDAT;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                oDONE   = 1'b1;
                state_d = S_FETCH;
                case (op_q[7:6])
                    2'b01: begin
                        if (op_q == 8'h76) state_d = S_HALT;
                        else begin dst_wr = 1'b1; dst_res = src_val; end
                    end
                    2'b10: alu_go = 1'b1;
                    2'b11: begin
                        if (sss == 3'b110) alu_go = 1'b1;
                        else oILL = 1'b1;
                    end
                    default: begin
                        case (sss)
                            3'b110: begin dst_wr = 1'b1; dst_res = opnd_q; end
                            3'b100: begin
                                dst_wr  = 1'b1;
                                dst_res = inc_res;
                                f_d     = mk_flags(inc_res, dst_val[3:0] == 4'hF, f_q[FLAG_C]);
                            end
                            3'b101: begin
                                dst_wr  = 1'b1;
                                dst_res = dec_res;
                                f_d     = mk_flags(dec_res, dst_val[3:0] == 4'h0, f_q[FLAG_C]);
                            end
                            default: oILL = 1'b1;
                        endcase
                    end
                endcase
                if (alu_go) begin
                    f_d = mk_flags(alu_res, alu_a, alu_c);
                    if (ooo != 3'b111) begin
                        rf_we  = 1'b1;
                        rf_idx = 3'd7;
                        rf_val = alu_res;
                    end
                end
                if (dst_wr) begin
                    if (ddd == 3'b110) begin
                        oMWR = 1'b1;
                        oMDT = dst_res;
                    end else begin
                        rf_we  = 1'b1;
                        rf_idx = ddd;
                        rf_val = dst_res;
                    end
                end
            end
            S_HALT:  oHLT = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            opnd_q  <= '0;
            f_q     <= '0;
            for (int i = 0; i < 8; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            f_q     <= f_d;
            if (rf_we) rf_q[rf_idx] <= rf_val;
        end
    end

    assign oACC  = rf_q[7];
    assign oFLG  = f_q;
    assign oRDAT = (iRSEL == 3'b110) ? f_q : rf_q[iRSEL];

endmodule

// File: tb/tb_alureg_seq.sv
// Directed bench for alureg_seq: 8-bit instance for the instruction set, 16-bit instance for width.
module tb_alureg_seq;

    logic        clk;
    logic        rst;
    logic        v8, v16;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [2:0]  rsel8, rsel16;
    logic        rdy8, done8, ill8, hlt8, mwr8;
    logic [7:0]  mdt8, acc8, flg8, r8;
    logic        rdy16, done16, ill16, hlt16, mwr16;
    logic [15:0] mdt16, acc16, flg16, r16;

    int          n_chk = 0;
    int          n_err = 0;
    logic        d_ill, d_mwr;
    logic [15:0] d_mdt;
    time         t_done, t0, t_base;
    logic [15:0] rv;
    int          cnt;

    alureg_seq #(.DATASIZE(8)) dut8 (
        .clk(clk), .rst(rst), .iVLD(v8), .iDAT(d8), .oRDY(rdy8), .oDONE(done8),
        .oILL(ill8), .oHLT(hlt8), .oMWR(mwr8), .oMDT(mdt8), .oACC(acc8), .oFLG(flg8),
        .iRSEL(rsel8), .oRDAT(r8)
    );

    alureg_seq #(.DATASIZE(16)) dut16 (
        .clk(clk), .rst(rst), .iVLD(v16), .iDAT(d16), .oRDY(rdy16), .oDONE(done16),
        .oILL(ill16), .oHLT(hlt16), .oMWR(mwr16), .oMDT(mdt16), .oACC(acc16), .oFLG(flg16),
        .iRSEL(rsel16), .oRDAT(r16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input bit w, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        if (w) begin v16 = 1'b1; d16 = b; end
        else   begin v8  = 1'b1; d8  = b[7:0]; end
        while (!(w ? rdy16 : rdy8) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("send_timeout", 16'(n), 16'd0);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic wait_done(input bit w);
        int n = 0;
        @(negedge clk);
        while (!(w ? done16 : done8) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) check("done_timeout", 16'(n), 16'd0);
        d_ill  = w ? ill16 : ill8;
        d_mwr  = w ? mwr16 : mwr8;
        d_mdt  = w ? mdt16 : {8'h00, mdt8};
        t_done = $time;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit w, input logic [15:0] op, input bit has, input logic [15:0] opnd);
        send(w, op);
        if (has) send(w, opnd);
        wait_done(w);
    endtask

    task automatic rd(input bit w, input logic [2:0] s, output logic [15:0] v);
        rsel8  = s;
        rsel16 = s;
        #1;
        v = w ? r16 : {8'h00, r8};
    endtask

    initial begin
        rst = 1'b1; v8 = 1'b0; v16 = 1'b0; d8 = '0; d16 = '0; rsel8 = '0; rsel16 = '0;
        repeat (2) @(negedge clk);
        check("rst_rdy",  {15'd0, rdy8},  16'd1);
        check("rst_done", {15'd0, done8}, 16'd0);
        check("rst_hlt",  {15'd0, hlt8},  16'd0);
        check("rst_mwr",  {15'd0, mwr8},  16'd0);
        check("rst_mdt",  {8'd0, mdt8},   16'h0000);
        check("rst_acc",  {8'd0, acc8},   16'h0000);
        check("rst_flg",  {8'd0, flg8},   16'h0000);
        check("rst_rdy16", {15'd0, rdy16}, 16'd1);
        rst = 1'b0;

        // 16-bit: 0xFFFF + 0x0001
        run(1, 16'h003E, 1, 16'hFFFF);
        run(1, 16'h0006, 1, 16'h0001);
        run(1, 16'h0080, 0, 16'h0);
        check("w16_acc", acc16, 16'h0000);
        check("w16_flg", flg16, 16'h0055);

        // ADI overflow into sign
        run(0, 16'h3E, 1, 16'h7F);
        run(0, 16'hC6, 1, 16'h01);
        check("adi_acc", {8'd0, acc8}, 16'h0080);
        check("adi_flg", {8'd0, flg8}, 16'h0090);

        // INR/DCR wrap
        run(0, 16'h06, 1, 16'hFF);
        run(0, 16'h04, 0, 16'h0);
        rd(0, 3'd0, rv);
        check("inr_b", rv, 16'h0000);
        check("inr_flg", {8'd0, flg8}, 16'h0054);
        run(0, 16'h05, 0, 16'h0);
        rd(0, 3'd0, rv);
        check("dcr_b", rv, 16'h00FF);
        check("dcr_flg", {8'd0, flg8}, 16'h0094);

        // CMP immediate, carry preserved by INR, then SBB
        run(0, 16'h3E, 1, 16'h05);
        run(0, 16'h06, 1, 16'h00);
        run(0, 16'hFE, 1, 16'h06);
        check("cpi_acc", {8'd0, acc8}, 16'h0005);
        check("cpi_flg", {8'd0, flg8}, 16'h0095);
        run(0, 16'h14, 0, 16'h0);
        rd(0, 3'd2, rv);
        check("inr_d", rv, 16'h0001);
        check("inr_d_flg", {8'd0, flg8}, 16'h0001);
        run(0, 16'h98, 0, 16'h0);
        check("sbb_acc", {8'd0, acc8}, 16'h0004);
        check("sbb_flg", {8'd0, flg8}, 16'h0000);
        check("sbb_mwr", {15'd0, d_mwr}, 16'd0);

        // memory destinations
        run(0, 16'h3E, 1, 16'h3C);
        run(0, 16'h77, 0, 16'h0);
        check("movma_mwr", {15'd0, d_mwr}, 16'd1);
        check("movma_mdt", d_mdt, 16'h003C);
        check("movma_acc", {8'd0, acc8}, 16'h003C);
        rd(0, 3'd0, rv);
        check("movma_b", rv, 16'h0000);
        run(0, 16'h36, 1, 16'h77);
        check("mvim_mwr", {15'd0, d_mwr}, 16'd1);
        check("mvim_mdt", d_mdt, 16'h0077);

        // MOV C,M with and without operand stall
        send(0, 16'h4E);
        t0 = $time;
        send(0, 16'hA5);
        wait_done(0);
        t_base = t_done - t0;
        rd(0, 3'd1, rv);
        check("movcm_c", rv, 16'h00A5);
        check("movcm_lat", 16'(t_base), 16'd14);
        send(0, 16'h4E);
        t0 = $time;
        repeat (3) @(negedge clk);
        send(0, 16'h5A);
        wait_done(0);
        rd(0, 3'd1, rv);
        check("movcm2_c", rv, 16'h005A);
        check("movcm_stall", 16'(t_done - t0 - t_base), 16'd30);

        // logic ops
        run(0, 16'hAF, 0, 16'h0);
        check("xra_acc", {8'd0, acc8}, 16'h0000);
        check("xra_flg", {8'd0, flg8}, 16'h0044);
        run(0, 16'hF6, 1, 16'h81);
        check("ori_acc", {8'd0, acc8}, 16'h0081);
        check("ori_flg", {8'd0, flg8}, 16'h0084);
        run(0, 16'hE6, 1, 16'h01);
        check("ani_acc", {8'd0, acc8}, 16'h0001);
        check("ani_flg", {8'd0, flg8}, 16'h0010);
        check("ani_ill", {15'd0, d_ill}, 16'd0);

        // illegal opcodes
        run(0, 16'h00, 0, 16'h0);
        check("nop_ill", {15'd0, d_ill}, 16'd1);
        check("nop_acc", {8'd0, acc8}, 16'h0001);
        check("nop_flg", {8'd0, flg8}, 16'h0010);
        run(0, 16'hC7, 0, 16'h0);
        check("c7_ill", {15'd0, d_ill}, 16'd1);
        check("c7_mwr", {15'd0, d_mwr}, 16'd0);

        // HLT
        run(0, 16'h76, 0, 16'h0);
        check("hlt_ill", {15'd0, d_ill}, 16'd0);
        check("hlt_hlt", {15'd0, hlt8}, 16'd1);
        check("hlt_rdy", {15'd0, rdy8}, 16'd0);
        cnt = 0;
        v8 = 1'b1; d8 = 8'h3E;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done8 || rdy8) cnt++;
        end
        v8 = 1'b0;
        check("hlt_ignore", 16'(cnt), 16'd0);
        check("hlt_hold", {15'd0, hlt8}, 16'd1);
        check("hlt_acc", {8'd0, acc8}, 16'h0001);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("unhlt_hlt", {15'd0, hlt8}, 16'd0);
        check("unhlt_rdy", {15'd0, rdy8}, 16'd1);
        rd(0, 3'd1, rv);
        check("unhlt_c", rv, 16'h0000);

        // reset mid-OPER of MVI A
        run(0, 16'h06, 1, 16'h11);
        send(0, 16'h3E);
        #2 rst = 1'b1;
        #1;
        check("rsto_rdy", {15'd0, rdy8}, 16'd1);
        check("rsto_done", {15'd0, done8}, 16'd0);
        rd(0, 3'd0, rv);
        check("rsto_b", rv, 16'h0000);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done8) cnt++;
        end
        check("rsto_nodone", 16'(cnt), 16'd0);
        check("rsto_acc", {8'd0, acc8}, 16'h0000);
        run(0, 16'h3E, 1, 16'h22);
        check("post_acc", {8'd0, acc8}, 16'h0022);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/alureg_seq.md
# alureg_seq

Parametrised successor to the single-cycle ALU/register datapath. It accepts an 8085-style instruction byte stream over a valid/ready handshake. A small state machine fetches the opcode, fetches an optional operand byte, executes, and writes the register file and flags. It supports MOV, MVI, INR, DCR, register/memory/immediate ALU ops and HLT, and reports memory-destination writes on a strobed output port.

## Interface
- DATASIZE, 8, datapath/register width (>= 5; nibble carry always taken from bit 3)
- FLAG_S, 7 / FLAG_Z, 6 / FLAG_A, 4 / FLAG_P, 2 / FLAG_C, 0: flag bit positions in F; all other F bits read 0
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- iVLD  in  1  iDAT holds a valid opcode/operand byte
- iDAT  in  DATASIZE  instruction stream byte
- oRDY  out  1  block accepts iDAT this cycle (transfer = iVLD & oRDY)
- oDONE  out  1  one-cycle pulse: instruction retires this cycle
- oILL  out  1  qualifies oDONE: opcode unsupported, executed as NOP
- oHLT  out  1  halted; only rst clears it
- oMWR  out  1  one-cycle memory-write strobe (destination 110)
- oMDT  out  DATASIZE  memory write data, valid with oMWR
- oACC  out  DATASIZE  accumulator (A) contents
- oFLG  out  DATASIZE  flag register (F) contents
- iRSEL  in  3  debug read select (B,C,D,E,H,L,F,A = 0..7)
- oRDAT  out  DATASIZE  combinational read of the register selected by iRSEL

## Operation
- Register file: B,C,D,E,H,L,A. Index 110 is F on the debug port only. As an operand, index 110 means the operand byte (M/immediate). As a destination, it means memory (oMWR/oMDT).
- Decode on the latched opcode op:
  - 01 ddd sss: MOV. 01110110 = HLT.
  - 10 ooo sss: ALU op ooo with A.
  - 11 ooo 110: ALU immediate.
  - 00 ddd 110: MVI.
  - 00 ddd 100: INR.
  - 00 ddd 101: DCR.
  - Everything else: illegal.
- Operand byte required when: sss=110 (MOV/ALU), ALU immediate, MVI, or INR/DCR with ddd=110.
- ALU ooo:
  - 000 ADD, 001 ADC: A+op+cin.
  - 010 SUB, 011 SBB: A-op-cin, C=borrow, A=nibble borrow.
  - 100 ANA: C=0, A=1.
  - 101 XRA, 110 ORA: C=0, A=0.
  - 111 CMP: SUB flags, A unchanged.
- Results go to A; S=msb, Z=(res==0), P=even parity of res.
- INR/DCR: result = dst±1 mod 2^DATASIZE. S, Z, P, A are updated; C is preserved.
- MOV/MVI: no flag change. A destination of 110 drives oMDT=value with oMWR=1 and leaves the register file untouched.
- Illegal: no register, flag or memory change; oDONE=1 and oILL=1.

## Timing
- States: FETCH, OPER, EXEC, HALT.
- FETCH: oRDY=1. On transfer, latch the opcode; go to OPER if an operand is needed, else EXEC.
- OPER: oRDY=1. On transfer, latch the operand and go to EXEC. With no transfer, wait indefinitely.
- EXEC: oRDY=0; oDONE=1, and oMWR/oILL when applicable. Register/flag write occurs on the clock edge ending EXEC. Next state is FETCH, or HALT if the opcode is HLT.
- HALT: oRDY=0; oHLT=1; all iVLD ignored.
- Latency from opcode transfer edge to register update:
  - 2 edges with no operand.
  - 2 edges plus the operand wait cycles (minimum 3) with an operand.
- Throughput: minimum 2 cycles per instruction with no operand, 3 with an operand.
- oACC/oFLG show new values in the cycle after EXEC.
- iVLD while oRDY=0 is not consumed; the source must hold the byte.
- Reset (any time, including mid-instruction in OPER/EXEC):
  - State goes to FETCH; the partial instruction is discarded with no write.
  - All registers and F = 0.
  - oDONE, oILL, oHLT, oMWR = 0; oMDT = 0.
  - oRDY = 1 (decoded from FETCH).

## Test plan
- Reset, then MVI A,0x7F then ADI 0x01 (C6 01): after 2 oDONE pulses, oACC=0x80 and F = S=1, Z=0, A=1, P=0, C=0 (0x90).
- MVI B,0xFF; INR B (04): oRDAT(B)=0x00, Z=1, A=1, P=1, C unchanged (0). Then DCR B gives 0xFF, S=1.
- A=0x05 via MVI; CMP imm 0x06 (FE 06): A stays 0x05, C=1, S=1, Z=0. SBB B with B=0x00 and C=1 gives A=0x04.
- MOV M,A (77) with A=0x3C: EXEC cycle oMWR=1, oMDT=0x3C; the register file is unchanged. MOV C,M (4E) with operand 0xA5 gives C=0xA5; iVLD held low 3 cycles in OPER delays oDONE by exactly 3 cycles.
- Opcode 0x00: oDONE=oILL=1, no state change. HLT (76): oHLT=1, oRDY=0, further bytes ignored; rst asserted mid-OPER of a pending MVI: state FETCH, registers 0, no oDONE.
- DATASIZE=16: ADD with A=0xFFFF, op=0x0001 gives A=0x0000, C=1, Z=1, A=1.
